// File: rtl/sdram_scanout.sv
// Video scan-out stage: raster timing generator plus read-FIFO pacing for the
// SDRAM controller's read port, with prefill gating, underflow fill and frame skip.
module sdram_scanout #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned DSIZE       = 16,
    parameter int unsigned PREFILL     = 256,
    parameter int unsigned LOAD_CYCLES = 4,
    parameter logic [DSIZE-1:0] UF_COLOR = '0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             ENABLE,
    input  logic             CLR_STATUS,
    input  logic [DSIZE-1:0] RD_DATA,
    input  logic             RD_EMPTY,
    input  logic [15:0]      RD_USE,
    output logic             RD,
    output logic             RD_LOAD,
    output logic             HS,
    output logic             VS,
    output logic             DE,
    output logic [DSIZE-1:0] PIX_DATA,
    output logic             FRAME_START,
    output logic             UNDERFLOW,
    output logic [7:0]       SKIP_CNT
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);
    localparam int unsigned LW = $clog2(LOAD_CYCLES + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [LW-1:0] L_LAST = LW'(LOAD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FILL, RUN} state_t;

    state_t          state, next_state;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic [LW-1:0]   load_cnt;
    logic            active, load_pt, start_pt, hs0, vs0;
    logic            empty_eff, de0, pop0, uf0, fs0, skip_inc;
    logic            de1, uf1, hs1, vs1, fs1, uf2;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        load_pt  = (h_cnt == '0) && (v_cnt == V_ACT);
        start_pt = (h_cnt == '0) && (v_cnt == '0);
        hs0      = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vs0      = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    end

    // RD_EMPTY lags a pop by one cycle; a pop still in flight against the
    // last word already makes the FIFO empty for this pixel.
    assign empty_eff = RD_EMPTY || (RD && (RD_USE <= 16'd1));

    always_comb begin
        next_state = state;
        skip_inc   = 1'b0;
        if (!ENABLE) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (load_pt) next_state = LOAD;
                    if (start_pt) skip_inc = 1'b1;
                end
                LOAD: begin
                    if (load_cnt == L_LAST) next_state = FILL;
                    if (start_pt) skip_inc = 1'b1;
                end
                FILL: begin
                    if (start_pt) begin
                        if (RD_USE >= 16'(PREFILL)) next_state = RUN;
                        else skip_inc = 1'b1;
                    end
                end
                RUN: begin
                    if (load_pt) next_state = LOAD;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Decode from next_state so the pixel at the frame start point is popped
    // in the same cycle FILL hands over to RUN.
    always_comb begin
        de0  = (next_state == RUN) && active;
        pop0 = de0 && !empty_eff;
        uf0  = de0 && empty_eff;
        fs0  = de0 && start_pt;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            load_cnt <= '0;
            RD_LOAD  <= 1'b0;
        end else begin
            state    <= next_state;
            load_cnt <= (state == LOAD) ? load_cnt + 1'b1 : '0;
            RD_LOAD  <= (next_state == LOAD);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            RD          <= 1'b0;
            de1         <= 1'b0;
            uf1         <= 1'b0;
            hs1         <= 1'b1;
            vs1         <= 1'b1;
            fs1         <= 1'b0;
            DE          <= 1'b0;
            uf2         <= 1'b0;
            HS          <= 1'b1;
            VS          <= 1'b1;
            FRAME_START <= 1'b0;
        end else begin
            RD          <= pop0;
            de1         <= de0;
            uf1         <= uf0;
            hs1         <= hs0;
            vs1         <= vs0;
            fs1         <= fs0;
            DE          <= de1;
            uf2         <= uf1;
            HS          <= hs1;
            VS          <= vs1;
            FRAME_START <= fs1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            UNDERFLOW <= 1'b0;
            SKIP_CNT  <= '0;
        end else begin
            if (uf0) UNDERFLOW <= 1'b1;
            else if (CLR_STATUS) UNDERFLOW <= 1'b0;
            if (CLR_STATUS) SKIP_CNT <= {7'b0, skip_inc};
            else if (skip_inc && (SKIP_CNT != 8'hFF)) SKIP_CNT <= SKIP_CNT + 1'b1;
        end
    end

    // Pixel words arrive straight from the FIFO's registered q, which lines
    // up with the registered control beat two cycles after the counters.
    assign PIX_DATA = DE ? (uf2 ? UF_COLOR : RD_DATA) : '0;

endmodule

// File: tb/tb_sdram_scanout.sv
// Scoreboard bench for sdram_scanout on a 14x7 raster with a queue-based FIFO
// model that reloads on RD_LOAD.
module tb_sdram_scanout;

    localparam int HT = 14;
    localparam int VT = 7;
    localparam logic [15:0] UFC = 16'hBEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        clr = 1'b0;
    logic [15:0] rd_data = '0;
    logic        rd_empty = 1'b1;
    logic [15:0] rd_use = '0;
    logic        rd, rd_load, hs, vs, de, fs, uf;
    logic [15:0] pix;
    logic [7:0]  skip;

    sdram_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .DSIZE(16), .PREFILL(32), .LOAD_CYCLES(4), .UF_COLOR(UFC)
    ) dut (
        .CLK(clk), .RESET_N(rst_n), .ENABLE(enable), .CLR_STATUS(clr),
        .RD_DATA(rd_data), .RD_EMPTY(rd_empty), .RD_USE(rd_use),
        .RD(rd), .RD_LOAD(rd_load), .HS(hs), .VS(vs), .DE(de),
        .PIX_DATA(pix), .FRAME_START(fs), .UNDERFLOW(uf), .SKIP_CNT(skip)
    );

    always #5 clk = ~clk;

    int tb_h, tb_v, h1, v1, h2, v2;
    int fill_n = 64;
    logic trunc_en = 1'b0;
    logic [15:0] fifo[$];

    // Reference raster position plus its two-cycle-delayed copy for output alignment
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tb_h <= 0; tb_v <= 0; h1 <= 0; v1 <= 0; h2 <= 0; v2 <= 0;
        end else begin
            h1 <= tb_h; v1 <= tb_v; h2 <= h1; v2 <= v1;
            if (tb_h == HT - 1) begin
                tb_h <= 0;
                tb_v <= (tb_v == VT - 1) ? 0 : tb_v + 1;
            end else begin
                tb_h <= tb_h + 1;
            end
        end
    end

    // Controller/FIFO model: RD_LOAD refills from the frame base, trunc_en drops
    // everything beyond 10 words at (1,0) to force a mid-frame underflow
    always @(posedge clk) begin
        if (rd_load) begin
            fifo.delete();
            for (int i = 0; i < fill_n; i++) fifo.push_back(16'(i));
        end else begin
            if (trunc_en && tb_h == 1 && tb_v == 0)
                while (fifo.size() > 10) void'(fifo.pop_back());
            if (rd && fifo.size() != 0) rd_data <= fifo.pop_front();
        end
        rd_use   <= 16'(fifo.size());
        rd_empty <= (fifo.size() == 0);
    end

    typedef struct { logic [15:0] d; int h; int v; } exp_t;
    exp_t sb[$];

    int checks = 0;
    int passes = 0;
    int rd_cycles = 0, rdload_cycles = 0, fs_count = 0, rd_on_empty = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic push_frame(input int n, input int valid_n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.d = (i < valid_n) ? 16'(i) : UFC;
            e.h = i % 8;
            e.v = i / 8;
            sb.push_back(e);
        end
    endtask

    task automatic wait_hv(input int h, input int v, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tb_h == h && tb_v == v) && n < 400);
        if (!(tb_h == h && tb_v == v)) begin
            checks++;
            $display("FAIL timeout %s: position %0d,%0d not reached, expected %0d,%0d", nm, tb_h, tb_v, h, v);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " RD"}, rd, 0);
        check({tag, " RD_LOAD"}, rd_load, 0);
        check({tag, " HS"}, hs, 1);
        check({tag, " VS"}, vs, 1);
        check({tag, " DE"}, de, 0);
        check({tag, " PIX_DATA"}, pix, 0);
        check({tag, " FRAME_START"}, fs, 0);
        check({tag, " UNDERFLOW"}, uf, 0);
        check({tag, " SKIP_CNT"}, skip, 0);
    endtask

    // Monitor: syncs against the delayed raster, pixels against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("hs", hs, !(h2 >= 10 && h2 < 12));
            check("vs", vs, !(v2 == 5));
            if (rd) rd_cycles++;
            if (rd && rd_empty) rd_on_empty++;
            if (rd_load) rdload_cycles++;
            if (fs) fs_count++;
            if (de) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_de: DE=1 at h=%0d v=%0d pix=0x%0h, expected DE=0", h2, v2, pix);
                end else begin
                    e = sb.pop_front();
                    check("pix", pix, e.d);
                    check("de_h", h2, e.h);
                    check("de_v", v2, e.v);
                    check("fs_on_de", fs, (e.h == 0 && e.v == 0));
                end
            end else begin
                check("pix_idle", pix, 0);
                check("fs_idle", fs, 0);
            end
        end
    end

    initial begin
        int hi, r0, l0, f0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        push_frame(32, 32);

        // F0: no load yet, frame skipped; load at v=4
        wait_hv(2, 0, "f0 start");
        check("f0 skip", skip, 1);
        wait_hv(0, 4, "f0 load pt");
        check("load early", rd_load, 0);
        @(negedge clk);
        check("load first", rd_load, 1);
        hi = 0;
        repeat (6) begin
            if (rd_load) hi++;
            @(negedge clk);
        end
        check("load width", hi, 4);
        fill_n = 32;

        // F1: 32 pixels 0..31
        wait_hv(0, 0, "f1 start");
        r0 = rd_cycles; f0 = fs_count;
        wait_hv(2, 0, "f1 arm");
        trunc_en = 1'b1;
        wait_hv(0, 4, "f1 end");
        check("f1 pops", rd_cycles - r0, 32);
        check("f1 fs count", fs_count - f0, 1);
        check("f1 drained", sb.size(), 0);
        check("f1 underflow", uf, 0);
        push_frame(32, 10);

        // F2: FIFO cut to 10 words, pixels 10+ substituted
        wait_hv(0, 0, "f2 start");
        r0 = rd_cycles;
        wait_hv(2, 0, "f2 arm");
        trunc_en = 1'b0;
        fill_n = 64;
        wait_hv(0, 4, "f2 end");
        check("f2 pops", rd_cycles - r0, 10);
        check("f2 underflow", uf, 1);
        check("f2 skip", skip, 1);
        check("f2 drained", sb.size(), 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("clr underflow", uf, 0);
        check("clr skip", skip, 0);
        push_frame(19, 19);

        // F3: ENABLE dropped at (3,2), re-enabled at (5,3)
        wait_hv(3, 2, "f3 drop");
        check("f3 rd before drop", rd, 1);
        enable = 1'b0;
        @(negedge clk);
        check("f3 rd after drop", rd, 0);
        check("f3 de last", de, 1);
        @(negedge clk);
        check("f3 de off", de, 0);
        wait_hv(5, 3, "f3 reenable");
        enable = 1'b1;
        fill_n = 20;
        wait_hv(0, 4, "f3 load pt");
        check("f3 no early load", rd_load, 0);
        check("f3 drained", sb.size(), 0);
        @(negedge clk);
        check("f3 load", rd_load, 1);

        // F4, F5: only 20 words, FILL persists
        wait_hv(0, 0, "f4 start");
        r0 = rd_cycles; l0 = rdload_cycles;
        wait_hv(2, 0, "f4 skip");
        check("f4 skip", skip, 1);
        wait_hv(0, 0, "f5 start");
        check("f4 no rd", rd_cycles - r0, 0);
        check("f4 no reload", rdload_cycles - l0, 0);
        wait_hv(2, 0, "f5 skip");
        check("f5 skip", skip, 2);

        // Asynchronous reset mid-active
        wait_hv(3, 1, "f5 reset");
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_hv(2, 0, "post reset start");
        check("post reset skip", skip, 1);
        wait_hv(0, 4, "post reset load pt");
        check("post reset no early load", rd_load, 0);
        @(negedge clk);
        check("post reset load", rd_load, 1);
        repeat (10) @(negedge clk);

        check("final drained", sb.size(), 0);
        check("rd while empty", rd_on_empty, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
